// File: rtl/cls_serial_add32.sv
// Byte-serial 32-bit adder/subtractor: one 8-bit slice is reused over four
// cycles, least-significant byte first, with a registered carry between bytes.
// Operands and results move through valid/ready handshakes.

// 8-bit carry-lookahead slice used for each byte step
module cls_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_start,
    output logic [7:0] sum,
    output logic       carry_out
);

    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;

    // Generate/propagate carry chain across the eight bit positions
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        carry[0] = carry_start;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum       = prop ^ carry[7:0];
        carry_out = carry[8];
    end

endmodule

module cls_serial_add32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_carry,
    output logic        out_ovf,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        carry_reg;
    logic [1:0]  idx;
    logic [23:0] res_lo;

    logic [7:0]  slice_a;
    logic [7:0]  slice_b;
    logic [7:0]  slice_sum;
    logic        slice_cout;
    logic [31:0] full_sum;

    // Subtraction is handled as A + ~B + 1, so the slice only ever adds
    assign slice_a  = a_reg[{idx, 3'b000} +: 8];
    assign slice_b  = b_reg[{idx, 3'b000} +: 8];
    assign full_sum = {slice_sum, res_lo};

    // Ready decodes the idle state and is held low while reset is applied
    assign in_ready = (state == IDLE) && !rst;

    cls_8bit u_slice (
        .a           (slice_a),
        .b           (slice_b),
        .carry_start (carry_reg),
        .sum         (slice_sum),
        .carry_out   (slice_cout)
    );

    // Sequencer: accept operands, run four byte steps, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= 2'd0;
            res_lo    <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_sub ? ~in_b : in_b;
                        carry_reg <= in_sub;
                        idx       <= 2'd0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    carry_reg <= slice_cout;
                    idx       <= idx + 2'd1;
                    case (idx)
                        2'd0: res_lo[7:0]   <= slice_sum;
                        2'd1: res_lo[15:8]  <= slice_sum;
                        2'd2: res_lo[23:16] <= slice_sum;
                        default: begin
                            out_sum   <= full_sum;
                            out_carry <= slice_cout;
                            out_ovf   <= (a_reg[31] == b_reg[31]) &&
                                         (slice_sum[7] != a_reg[31]);
                            out_zero  <= ~|full_sum;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
